// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit BCD display scanner: per-slot blanking, frame-synchronous
// display updates, invalid-code and leading-zero digit suppression.
module display_scan_controller #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lzb_en,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic [3:0]  digit_sel,
  output logic        load_ack,
  output logic        frame_done
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SlotW-1:0] SlotLast  = SlotW'(SCAN_DIV - 1);
  localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYC - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       disp_q, disp_d, stg_q, stg_d;
  logic [3:0]        disp_dp_q, disp_dp_d, stg_dp_q, stg_dp_d;
  logic              pend_q, pend_d;
  logic [3:0]        sel_q, sel_d, bcd_q, bcd_d;
  logic              dp_q, dp_d, ack_q, ack_d, done_q, done_d;
  logic              frame_end, lead_zero, suppress;

  always_comb begin
    frame_end = (idx_q == 2'd3) && (slot_q == SlotLast);
    state_d   = state_q;
    slot_d    = slot_q + SlotW'(1);
    idx_d     = idx_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    stg_d     = stg_q;
    stg_dp_d  = stg_dp_q;
    pend_d    = pend_q;

    unique case (state_q)
      StBlank: if (slot_q == BlankLast) state_d = StDrive;
      StDrive: if (slot_q == SlotLast) state_d = StBlank;
    endcase

    if (slot_q == SlotLast) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    if (load) begin
      stg_d    = bcd_in;
      stg_dp_d = dp_in;
      pend_d   = 1'b1;
    end

    // A load on the boundary edge bypasses staging so it is not held a whole frame.
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        disp_d    = bcd_in;
        disp_dp_d = dp_in;
      end else if (pend_q) begin
        disp_d    = stg_q;
        disp_dp_d = stg_dp_q;
      end
    end

    ack_d  = frame_end && (load || pend_q);
    done_d = frame_end;
  end

  // Outputs are decoded from next-state values so the registered outputs track slot_q.
  always_comb begin
    bcd_d = disp_d[{idx_d, 2'b00} +: 4];
    dp_d  = disp_dp_d[idx_d];
    unique case (idx_d)
      2'd3:    lead_zero = (disp_d[15:12] == 4'd0);
      2'd2:    lead_zero = (disp_d[15:8] == 8'd0);
      2'd1:    lead_zero = (disp_d[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
    suppress = (bcd_d > 4'd9) || (lzb_en && lead_zero && !dp_d);
    sel_d    = 4'b1111;
    if (state_d == StDrive && !suppress) sel_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBlank;
      slot_q    <= '0;
      idx_q     <= 2'd0;
      disp_q    <= 16'd0;
      disp_dp_q <= 4'd0;
      stg_q     <= 16'd0;
      stg_dp_q  <= 4'd0;
      pend_q    <= 1'b0;
      sel_q     <= 4'b1111;
      bcd_q     <= 4'd0;
      dp_q      <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      stg_q     <= stg_d;
      stg_dp_q  <= stg_dp_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
    end
  end

  assign digit_sel  = sel_q;
  assign bcd_out    = bcd_q;
  assign dp_out     = dp_q;
  assign load_ack   = ack_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with SCAN_DIV=10, BLANK_CYC=2.
module tb_display_scan_controller;

  localparam int FrameLen = 40;
  localparam logic [10:0] RstObs = 11'h780;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  bcd_out, digit_sel;
  logic        dp_out, load_ack, frame_done;
  logic [10:0] obs;

  int total = 0;
  int bad = 0;

  logic [10:0] sb[$];
  int          m_pos = 0;
  logic [15:0] m_v = 16'h0, m_sv = 16'h0;
  logic [3:0]  m_d = 4'h0, m_sd = 4'h0;
  logic        m_pend = 1'b0;

  display_scan_controller #(
    .SCAN_DIV (10),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .lzb_en    (lzb_en),
    .bcd_out   (bcd_out),
    .dp_out    (dp_out),
    .digit_sel (digit_sel),
    .load_ack  (load_ack),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {digit_sel, bcd_out, dp_out, load_ack, frame_done};

  // Expected outputs for frame position pos (idx*10 + slot count).
  function automatic logic [10:0] expect_out(int pos, logic [15:0] v, logic [3:0] d, logic lz,
                                             logic ack, logic done);
    int          idx;
    int          slot;
    logic [15:0] sh;
    logic [3:0]  code;
    logic [3:0]  sel;
    logic        sup;
    idx  = pos / 10;
    slot = pos % 10;
    sh   = v >> (4 * idx);
    code = sh[3:0];
    sup  = (code > 4'd9) || (lz && idx > 0 && sh == 16'h0 && !d[idx]);
    sel  = 4'b1111;
    if (slot >= 2 && !sup) sel[idx] = 1'b0;
    return {sel, code, d[idx], ack, done};
  endfunction

  initial begin
    logic bnd, ack;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pos = 0; m_v = 16'h0; m_d = 4'h0; m_sv = 16'h0; m_sd = 4'h0; m_pend = 1'b0;
        sb.delete();
      end else begin
        bnd = (m_pos == FrameLen - 1);
        ack = bnd && (load || m_pend);
        if (bnd) begin
          if (load) begin
            m_v = bcd_in; m_d = dp_in;
          end else if (m_pend) begin
            m_v = m_sv; m_d = m_sd;
          end
          m_pend = 1'b0;
        end else if (load) begin
          m_sv = bcd_in; m_sd = dp_in; m_pend = 1'b1;
        end
        m_pos = (m_pos + 1) % FrameLen;
        sb.push_back(expect_out(m_pos, m_v, m_d, lzb_en, ack, bnd));
      end
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== RstObs) begin
      bad++; $display("FAIL reset_async: got %h want %h", obs, RstObs);
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs !== RstObs) begin
      bad++; $display("FAIL reset_hold: got %h want %h", obs, RstObs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [10:0] e;
    int dones = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL idle_scan: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL idle_scan cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (frame_done) dones++;
    end
    total++;
    if (dones !== 2) begin
      bad++; $display("FAIL idle_frame_done_count: got %0d want 2", dones);
    end
  endtask

  task automatic test_load();
    logic [10:0] e;
    int acks = 0;
    int f = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL load: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL load cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (load_ack) acks++;
      if (m_pos == 0) f++;
      load = 1'b0;
      if (f == 1 && m_pos == 15) begin
        load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;
      end
      if (f == 3 && m_pos == FrameLen - 1) begin
        load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0001;
      end
    end
    load = 1'b0;
    total++;
    if (acks !== 2) begin
      bad++; $display("FAIL load_ack_count: got %0d want 2", acks);
    end
  endtask

  task automatic test_double_load();
    logic [10:0] e;
    int acks = 0;
    int f = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL double_load: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL double_load cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (load_ack) acks++;
      if (m_pos == 0) f++;
      load = 1'b0;
      if (f == 1 && m_pos == 5) begin
        load = 1'b1; bcd_in = 16'h1111; dp_in = 4'b0000;
      end
      if (f == 1 && m_pos == 20) begin
        load = 1'b1; bcd_in = 16'h2222; dp_in = 4'b0000;
      end
    end
    load = 1'b0;
    total++;
    if (acks !== 1) begin
      bad++; $display("FAIL double_load_ack_count: got %0d want 1", acks);
    end
  endtask

  task automatic test_lzb();
    logic [10:0] e;
    int f = 0;
    lzb_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL lzb: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL lzb cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (m_pos == 0) f++;
      load = 1'b0;
      if (f == 1 && m_pos == 3) begin
        load = 1'b1; bcd_in = 16'h0050; dp_in = 4'b0000;
      end
      if (f == 3 && m_pos == 3) begin
        load = 1'b1; bcd_in = 16'h0050; dp_in = 4'b1000;
      end
    end
    load = 1'b0;
    lzb_en = 1'b0;
  endtask

  task automatic test_invalid();
    logic [10:0] e;
    int f = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL invalid: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL invalid cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (m_pos == 0) f++;
      load = 1'b0;
      if (f == 1 && m_pos == 3) begin
        load = 1'b1; bcd_in = 16'h00A0; dp_in = 4'b0000;
      end
      lzb_en = (f >= 3);
    end
    load = 1'b0;
    lzb_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] e;
    int f = 0;
    int acks = 0;
    int dones = 0;
    bit hit = 0;
    for (int k = 0; k < 120 && !hit; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL reset_mid_pre: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL reset_mid_pre cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (m_pos == 0) f++;
      load = 1'b0;
      if (f == 1 && m_pos == 22) begin
        load = 1'b1; bcd_in = 16'h9876; dp_in = 4'b1111;
      end
      if (f == 1 && m_pos == 25) begin
        hit = 1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RstObs) begin
          bad++; $display("FAIL reset_mid_async: got %h want %h", obs, RstObs);
        end
      end
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL reset_mid_reach: got 0 want 1");
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== RstObs) begin
      bad++; $display("FAIL reset_mid_hold: got %h want %h", obs, RstObs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL reset_mid_post: no expected entry, got %h", obs);
      end else begin
        e = sb.pop_front();
        if (obs !== e) begin
          bad++; $display("FAIL reset_mid_post cyc %0d: got %h want %h", k, obs, e);
        end
      end
      if (load_ack) acks++;
      if (frame_done) dones++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL reset_mid_ack_count: got %0d want 0", acks);
    end
    total++;
    if (dones !== 2) begin
      bad++; $display("FAIL reset_mid_done_count: got %0d want 2", dones);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load();
    test_double_load();
    test_lzb();
    test_invalid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot (1 kHz per digit at 50 MHz).
REQ-002 Parameter BLANK_CYC, default 500: inter-digit blanking cycles at the start of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 bcd_in  in  16  four BCD digits; [3:0] = digit 0 (least significant) through [15:12] = digit 3.
REQ-006 dp_in  in  4  decimal point per digit; bit n belongs to digit n.
REQ-007 load  in  1  one-cycle request to capture bcd_in/dp_in.
REQ-008 lzb_en  in  1  leading-zero blanking enable; sampled every cycle.
REQ-009 bcd_out  out  4  BCD code for the shared BCD-to-7-segment decoder.
REQ-010 dp_out  out  1  decimal point for the shared decoder.
REQ-011 digit_sel  out  4  active-low one-hot common-cathode digit enable; 4'b1111 = all digits off.
REQ-012 load_ack  out  1  one-cycle pulse when captured data becomes visible.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each digit-3 slot.

Function
REQ-014 The block SHALL run a slot counter over 0..SCAN_DIV-1 and a digit index over 0..3, wrapping 3->0.
REQ-015 The FSM SHALL have two states:
- BLANK: slot count < BLANK_CYC; digit_sel = 4'b1111.
- DRIVE: remaining cycles of the slot; digit_sel bit[idx] = 0 unless the digit is suppressed.
REQ-016 BLANK->DRIVE SHALL occur when slot count reaches BLANK_CYC.
REQ-017 DRIVE->BLANK SHALL occur at slot count SCAN_DIV-1; on the same edge the index advances and the slot counter returns to 0.
REQ-018 bcd_out/dp_out SHALL present the display-register digit[idx] during both BLANK and DRIVE, so decoder inputs settle before the digit is enabled.
REQ-019 Outputs SHALL be registered; digit_sel, bcd_out and dp_out change on the same clock edge.
REQ-020 Capture: load=1 SHALL copy bcd_in/dp_in into a staging register and set a pending flag; a further load while pending overwrites staging and leaves pending set.
REQ-021 Frame boundary (idx=3, slot count SCAN_DIV-1): when pending, staging SHALL transfer to the display register, pending SHALL clear, and load_ack SHALL pulse one cycle later, aligned with the digit-0 BLANK start.
REQ-022 Load coinciding with the frame boundary: the incoming bcd_in/dp_in SHALL transfer directly to the display register, pending SHALL clear, and load_ack SHALL pulse.
REQ-023 frame_done SHALL pulse in the cycle after every frame boundary, whether or not a load occurred.
REQ-024 A digit code > 9 SHALL be suppressed (digit_sel stays 4'b1111 for that slot's DRIVE).
REQ-025 Leading-zero blanking: when lzb_en=1, digit n (n = 3..1) SHALL be suppressed if it and all higher digits equal 0 and its dp bit is 0; digit 0 is never suppressed by blanking.
REQ-026 Display data SHALL never change mid-frame; all four digits of a frame come from one display-register value.

Reset
REQ-027 While rst_n=0, regardless of clk:
- digit_sel = 4'b1111; bcd_out, dp_out, load_ack and frame_done = 0.
- display, staging and pending = 0; idx = 0; slot count = 0; state = BLANK.
REQ-028 After rst_n rises, the first slot SHALL be a full BLANK + DRIVE of digit 0.
REQ-029 A reset mid-slot or mid-frame SHALL discard pending data; no load_ack is produced for it.

Verification (SCAN_DIV=10, BLANK_CYC=2)
REQ-030 Reset release, no load: digit_sel is 1111 for 2 cycles, then 1110 for 8 cycles, then the same pattern through 1101, 1011, 0111; bcd_out=0; frame_done pulses every 40 cycles.
REQ-031 load with bcd_in=16'h1234, dp_in=4'b0100 mid-frame: no change until the frame boundary, then load_ack pulses once; next frame shows bcd_out 4,3,2,1 on idx 0..3, with dp_out=1 only on idx 2.
REQ-032 Two loads (16'h1111, then 16'h2222) in one frame: a single load_ack pulse; next frame shows 2222.
REQ-033 lzb_en=1, value 16'h0050, dp_in=0: digits 3 and 2 are suppressed (digit_sel=1111 in their DRIVE); digits 1 and 0 are driven with 5 and 0. Setting dp_in=4'b1000 re-enables digit 3.
REQ-034 Value 16'h00A0: digit 1 is suppressed irrespective of lzb_en.
REQ-035 rst_n pulsed low at idx=2 while a load is pending: outputs take reset values immediately; no load_ack; scanning restarts at digit 0 with value 0.
